fp32_mul_iter: RTL and testbench
================================

Name: fp32_mul_iter

Overview:
- Iterative single-precision (IEEE-754 binary32) floating-point multiplier.
- Acts as the responder on the FPU start/done/busy operation handshake that the divider FSM drives. It serves the D·x and N·x products of the Newton-Raphson loop.
- Mantissa product is built by radix-2^RADIX_BITS shift-add over multiple cycles, trading latency for area.

Parameters:
- RADIX_BITS, 1, multiplier bits consumed per MULT cycle. Legal values: 1, 2, 3, 4, 6, 8. MULT phase lasts 24/RADIX_BITS cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- N1  input  32  operand A, captured on accepted start.
- N2  input  32  operand B, captured on accepted start.
- result  output  32  product; registered, holds until the next done.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- busy  output  1  high from the cycle after accept through the DONE cycle inclusive.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, result=0, done=0, busy=0, internal accumulator and counter cleared. Reset aborts any in-flight operation; no done is produced for it.
- States: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE -> IDLE. UNPACK goes directly to DONE for special operands.
- IDLE, start=1: latch N1/N2 and go to UNPACK. start is ignored in every other state, including DONE. No queueing.
- UNPACK:
  - sign = sA^sB.
  - exp field 0 means zero (denormals flushed to zero on input).
  - Special results, selected in priority order:
    - any NaN, or inf*0 -> 0x7FC00000
    - inf*nonzero -> signed inf
    - zero*finite -> signed zero
  - Otherwise: mantissas with hidden 1 loaded; 10-bit signed exponent = eA + eB - 127; counter cleared.
- MULT: each cycle, add mantissaA × (next RADIX_BITS of mantissaB, LSB first) into the 48-bit product register, then shift. Exit when counter reaches 24/RADIX_BITS - 1.
- NORM: if product bit 47 is set, shift right 1 and increment exponent. Form 24-bit mantissa plus guard bit and sticky bit (OR of the remaining low bits).
- ROUND:
  - Apply the rounding rule (see Optional Feature). Mantissa carry-out renormalizes with exponent +1.
  - Exponent ≥ 255 -> signed inf (0x7F800000 | sign).
  - Exponent ≤ 0 -> signed zero (flush to zero).
- DONE: result register updated, done=1 for exactly this cycle, busy=1. Next state is IDLE.
- Latency, with start accepted in cycle 0:
  - normal operands: done in cycle 4 + 24/RADIX_BITS (28 for RADIX_BITS=1).
  - special operands: done in cycle 2.
- Back-to-back: earliest next accept is the cycle after DONE.
- Inputs N1/N2 may change freely after accept without affecting the result.

Optional Feature:
- Macro FP32_MUL_RNE_EN.
- Defined: round-to-nearest-even. Increment when guard=1 and (sticky=1 or mantissa LSB=1). Overflow yields inf.
- Undefined: truncate (round toward zero); guard and sticky are discarded. Overflow yields the largest finite magnitude (0x7F7FFFFF | sign) instead of inf.
- Latency is identical in both builds.

Test Plan:
- Basic product, RADIX_BITS=1: N1=0x3FC00000 (1.5), N2=0x40000000 (2.0), start pulse in cycle 0 -> busy high cycles 1–28, done only in cycle 28, result=0x40400000.
- Tie rounding: 0x3F800001 × 0x3FC00000 -> 0x3FC00002 with FP32_MUL_RNE_EN; 0x3FC00001 without.
- Specials:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, done in cycle 2.
  - 0xFF800000 × 0x40000000 -> 0xFF800000, done in cycle 2.
- Overflow/underflow:
  - 0x7F7FFFFF × 0x40000000 -> 0x7F800000 (RNE build) or 0x7F7FFFFF (truncate build).
  - 0x80800000 × 0x3F000000 -> 0x80000000.
- Handshake abuse:
  - start held high for 40 cycles -> exactly one op per IDLE visit; starts seen in busy cycles are ignored.
  - rst asserted in cycle 10 -> cycle 11 busy=0, done=0, result=0; no stale done follows.
  - A fresh 1.5×2.0 afterwards completes normally.
- Parameter sweep: RADIX_BITS=4, 1.5×2.0 -> done in cycle 10, result=0x40400000; 1000 random normal operand pairs match the reference model bit-exactly.

Source files
------------

// File: rtl/fp32_mul_iter.sv
// fp32_mul_iter: iterative binary32 multiplier, radix-2^RADIX_BITS shift-add mantissa product.
// FP32_MUL_RNE_EN selects round-to-nearest-even; otherwise truncate with overflow to max finite.
module fp32_mul_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] N1,
  input  logic [31:0] N2,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);
  localparam int STEPS = 24 / RADIX_BITS;
`ifdef FP32_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;
  state_t state, state_d;
  logic [31:0] a_r, b_r;
  logic        sign, guard, sticky;
  logic [9:0]  ex;
  logic [23:0] ma, mb, mant;
  logic [47:0] prod;
  logic [4:0]  cnt;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, s_ab;
  logic [31:0] spec_res, rnd_res;
  logic [23+RADIX_BITS:0] sum;
  logic        inc, ovf, unf;
  logic [24:0] mr;
  logic [9:0]  er;
  logic [22:0] frac;
  assign s_ab     = a_r[31] ^ b_r[31];
  assign a_zero   = a_r[30:23] == 8'd0;
  assign b_zero   = b_r[30:23] == 8'd0;
  assign a_inf    = &a_r[30:23] & ~|a_r[22:0];
  assign b_inf    = &b_r[30:23] & ~|b_r[22:0];
  assign a_nan    = &a_r[30:23] & |a_r[22:0];
  assign b_nan    = &b_r[30:23] & |b_r[22:0];
  assign special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign spec_res = (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) ? 32'h7FC00000 :
                    (a_inf | b_inf) ? {s_ab, 8'hFF, 23'd0} : {s_ab, 31'd0};
  assign sum      = {{RADIX_BITS{1'b0}}, prod[47:24]} +
                    {{RADIX_BITS{1'b0}}, ma} * {24'd0, mb[RADIX_BITS-1:0]};
  assign inc      = RNE & guard & (sticky | mant[0]);
  assign mr       = {1'b0, mant} + {24'd0, inc};
  assign er       = ex + {9'd0, mr[24]};
  assign frac     = mr[24] ? mr[23:1] : mr[22:0];
  assign ovf      = $signed(er) > $signed(10'd254);
  assign unf      = $signed(er) < $signed(10'd1);
  assign rnd_res  = ovf ? (RNE ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF}) :
                    unf ? {sign, 31'd0} : {sign, er[7:0], frac};
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? UNPACK : IDLE;
      UNPACK:  state_d = special ? DONE : MULT;
      MULT:    state_d = (cnt == 5'(STEPS - 1)) ? NORM : MULT;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= 32'd0;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      sign   <= 1'b0;
      ex     <= 10'd0;
      ma     <= 24'd0;
      mb     <= 24'd0;
      prod   <= 48'd0;
      cnt    <= 5'd0;
      mant   <= 24'd0;
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        a_r <= N1;
        b_r <= N2;
      end
      if (state == UNPACK) begin
        sign <= s_ab;
        ma   <= {1'b1, a_r[22:0]};
        mb   <= {1'b1, b_r[22:0]};
        ex   <= {2'b0, a_r[30:23]} + {2'b0, b_r[30:23]} - 10'd127;
        cnt  <= 5'd0;
        prod <= 48'd0;
        if (special) result <= spec_res;
      end
      // accumulate into the top half, then shift the consumed digit out the bottom
      if (state == MULT) begin
        prod <= {sum, prod[23:RADIX_BITS]};
        mb   <= mb >> RADIX_BITS;
        cnt  <= cnt + 5'd1;
      end
      if (state == NORM) begin
        mant   <= prod[47] ? prod[47:24] : prod[46:23];
        guard  <= prod[47] ? prod[23] : prod[22];
        sticky <= prod[47] ? |prod[22:0] : |prod[21:0];
        ex     <= ex + {9'd0, prod[47]};
      end
      if (state == ROUND) result <= rnd_res;
    end
  end
endmodule

// File: tb/tb_fp32_mul_iter.sv
// tb_fp32_mul_iter: table vectors, handshake sequences and random products against an integer reference.
module tb_fp32_mul_iter;
`ifdef FP32_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] N1 = 32'd0, N2 = 32'd0;
  logic [31:0] result1, result4;
  logic done1, busy1, done4, busy4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fp32_mul_iter #(.RADIX_BITS(1)) dut1 (.clk(clk), .rst(rst), .start(start), .N1(N1), .N2(N2),
    .result(result1), .done(done1), .busy(busy1));
  fp32_mul_iter #(.RADIX_BITS(4)) dut4 (.clk(clk), .rst(rst), .start(start), .N1(N1), .N2(N2),
    .result(result4), .done(done4), .busy(busy4));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          sp;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    bit an, bn, ai, bi, az, bz;
    logic [63:0] p, m, rem, half;
    int sh;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    p  = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    e  = ea + eb - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (RNE && (rem > half || (rem == half && m[0]))) m++;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return RNE ? {s, 8'hFF, 23'd0} : {s, 31'h7F7FFFFF};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), m[22:0]};
  endfunction
  function automatic logic [31:0] rnd_norm();
    logic [7:0] e;
    e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(90, 165));
    return {1'($urandom), e, 23'($urandom)};
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r1,
                        output logic [31:0] r4, output int c1, output int c4, output int n4,
                        output bit bz);
    N1 = a;
    N2 = b;
    start = 1'b1;
    c1 = -1;
    c4 = -1;
    n4 = 0;
    bz = 1'b1;
    r1 = 'x;
    r4 = 'x;
    @(posedge clk); #1;
    start = 1'b0;
    N1 = $urandom;
    N2 = $urandom;
    for (int c = 1; c <= 40 && c1 < 0; c++) begin
      if (!busy1) bz = 1'b0;
      if (done4) begin
        n4++;
        if (c4 < 0) begin
          c4 = c;
          r4 = result4;
        end
      end
      if (done1) begin
        c1 = c;
        r1 = result1;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [31:0] r1, r4, a, b, e;
    int c1, c4, n4, k1, k4, d1a, d1b;
    bit bz;
    v[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0};
    v[1]  = '{32'h3F800001, 32'h3FC00000, RNE ? 32'h3FC00002 : 32'h3FC00001, 1'b0};
    v[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    v[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1};
    v[4]  = '{32'h7F7FFFFF, 32'h40000000, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 1'b0};
    v[5]  = '{32'h80800000, 32'h3F000000, 32'h80000000, 1'b0};
    v[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1};
    v[7]  = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b1};
    v[8]  = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b1};
    v[9]  = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b1};
    v[10] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0};
    v[11] = '{32'h40400000, 32'h40400000, 32'h41100000, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result1", result1, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_result4", result4, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].a, v[i].b, r1, r4, c1, c4, n4, bz);
      chk($sformatf("vec%0d_r1", i), r1, v[i].r);
      chk($sformatf("vec%0d_r4", i), r4, v[i].r);
      chk($sformatf("vec%0d_lat1", i), 32'(c1), v[i].sp ? 32'd2 : 32'd28);
      chk($sformatf("vec%0d_lat4", i), 32'(c4), v[i].sp ? 32'd2 : 32'd10);
      chk($sformatf("vec%0d_ndone4", i), 32'(n4), 32'd1);
      chk($sformatf("vec%0d_busy1", i), {31'd0, bz}, 32'd1);
    end
    N1 = 32'h3FC00000;
    N2 = 32'h40000000;
    start = 1'b1;
    k1 = 0;
    k4 = 0;
    d1a = -1;
    d1b = -1;
    for (int c = 0; c <= 70; c++) begin
      if (c == 40) start = 1'b0;
      if (done1) begin
        k1++;
        if (d1a < 0) d1a = c;
        else d1b = c;
      end
      if (done4) k4++;
      @(posedge clk); #1;
    end
    chk("hold_ndone1", 32'(k1), 32'd2);
    chk("hold_first1", 32'(d1a), 32'd28);
    chk("hold_second1", 32'(d1b), 32'd57);
    chk("hold_ndone4", 32'(k4), 32'd4);
    chk("hold_result1", result1, 32'h40400000);
    start = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        rst = 1'b0;
        chk("abort_busy1", {31'd0, busy1}, 32'd0);
        chk("abort_done1", {31'd0, done1}, 32'd0);
        chk("abort_result1", result1, 32'd0);
        chk("abort_busy4", {31'd0, busy4}, 32'd0);
        chk("abort_result4", result4, 32'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    k1 = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1 || done4) k1++;
      @(posedge clk); #1;
    end
    chk("abort_stale_done", 32'(k1), 32'd0);
    run_op(32'h3FC00000, 32'h40000000, r1, r4, c1, c4, n4, bz);
    chk("fresh_r1", r1, 32'h40400000);
    chk("fresh_lat1", 32'(c1), 32'd28);
    chk("fresh_r4", r4, 32'h40400000);
    chk("fresh_lat4", 32'(c4), 32'd10);
    for (int i = 0; i < 1000; i++) begin
      a = rnd_norm();
      b = rnd_norm();
      e = ref_mul(a, b);
      run_op(a, b, r1, r4, c1, c4, n4, bz);
      chk($sformatf("rand%0d_r1 %h*%h", i, a, b), r1, e);
      chk($sformatf("rand%0d_r4 %h*%h", i, a, b), r4, e);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
